// File: rtl/jesd204b_pkg.sv
// Shared JESD204B link-layer constants, FSM encodings and the captured link-configuration record.
// Used by both the TX ILA generator and the RX ILA checker.
package jesd204b_pkg;

  localparam int LINK_CONF_OCTET_NUM = 14;

  localparam logic [7:0] K28_0 = 8'h1C;  // /R/
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/
  localparam logic [7:0] K28_5 = 8'hBC;  // /K/

  localparam logic [2:0] SUBCLASSV = 3'd2;
  localparam logic [2:0] JESDV     = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_R,
    ST_RUN,
    ST_ERR
  } ila_state_t;

  typedef struct packed {
    logic [7:0] did;
    logic [3:0] adjcnt;
    logic [3:0] bid;
    logic       adjdir;
    logic       phadj;
    logic [4:0] lid;
    logic       scr;
    logic [4:0] l;
    logic [7:0] f;
    logic [4:0] k;
    logic [7:0] m;
    logic [1:0] cs;
    logic [4:0] n;
    logic [4:0] n_ap;
    logic [2:0] subclassv;
    logic [2:0] jesdv;
    logic [4:0] s;
    logic       hd;
    logic [4:0] cf;
  } ila_cfg_t;

endpackage

// File: rtl/ila_cfg_parser.sv
// Captures the 14 link-configuration octets by index, accumulates the field-wise FCHK sum.
// Results valid 1 cycle after the FCHK octet; no backpressure, captures only when cap_vld.
module ila_cfg_parser
  import jesd204b_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       cap_vld,
  input  logic [3:0] cap_idx,
  input  logic [7:0] cap_dat,
  input  logic [7:0] exp_f,
  input  logic [4:0] exp_k,
  output ila_cfg_t   cfg,
  output logic       cfg_vld,
  output logic       fchk_err,
  output logic       cfg_mismatch
);

  localparam logic [3:0] FCHK_IDX = 4'(LINK_CONF_OCTET_NUM - 1);

  ila_cfg_t    cfg_q, cfg_d;
  logic [11:0] acc_q, acc_d;
  logic        vld_q, vld_d;
  logic        ferr_q, ferr_d;
  logic        mm_q, mm_d;
  logic [11:0] contrib;

  always_comb begin
    cfg_d   = cfg_q;
    acc_d   = acc_q;
    vld_d   = vld_q;
    ferr_d  = ferr_q;
    mm_d    = mm_q;
    contrib = '0;
    if (cap_vld) begin
      case (cap_idx)
        4'd0: begin cfg_d.did = cap_dat; contrib = 12'(cap_dat); end
        4'd1: begin
          cfg_d.adjcnt = cap_dat[7:4];
          cfg_d.bid    = cap_dat[3:0];
          contrib      = 12'(cap_dat[7:4]) + 12'(cap_dat[3:0]);
        end
        4'd2: begin
          cfg_d.adjdir = cap_dat[6];
          cfg_d.phadj  = cap_dat[5];
          cfg_d.lid    = cap_dat[4:0];
          contrib      = 12'(cap_dat[6]) + 12'(cap_dat[5]) + 12'(cap_dat[4:0]);
        end
        4'd3: begin
          cfg_d.scr = cap_dat[7];
          cfg_d.l   = cap_dat[4:0];
          contrib   = 12'(cap_dat[7]) + 12'(cap_dat[4:0]);
        end
        4'd4: begin cfg_d.f = cap_dat; contrib = 12'(cap_dat); end
        4'd5: begin cfg_d.k = cap_dat[4:0]; contrib = 12'(cap_dat[4:0]); end
        4'd6: begin cfg_d.m = cap_dat; contrib = 12'(cap_dat); end
        4'd7: begin
          cfg_d.cs = cap_dat[7:6];
          cfg_d.n  = cap_dat[4:0];
          contrib  = 12'(cap_dat[7:6]) + 12'(cap_dat[4:0]);
        end
        4'd8: begin
          cfg_d.subclassv = cap_dat[7:5];
          cfg_d.n_ap      = cap_dat[4:0];
          contrib         = 12'(cap_dat[7:5]) + 12'(cap_dat[4:0]);
        end
        4'd9: begin
          cfg_d.jesdv = cap_dat[7:5];
          cfg_d.s     = cap_dat[4:0];
          contrib     = 12'(cap_dat[7:5]) + 12'(cap_dat[4:0]);
        end
        4'd10: begin
          cfg_d.hd = cap_dat[7];
          cfg_d.cf = cap_dat[4:0];
          contrib  = 12'(cap_dat[7]) + 12'(cap_dat[4:0]);
        end
        FCHK_IDX: begin
          // F and K octets were captured earlier in this multiframe, so cfg_q is already settled.
          vld_d  = 1'b1;
          ferr_d = (acc_q[7:0] != cap_dat);
          mm_d   = (cfg_q.f != exp_f) || (cfg_q.k != exp_k);
        end
        default: ;  // RES1/RES2 carry no checked content
      endcase
      acc_d = acc_q + contrib;
    end
    if (clr) begin
      cfg_d  = '0;
      acc_d  = '0;
      vld_d  = 1'b0;
      ferr_d = 1'b0;
      mm_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q  <= '0;
      acc_q  <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      mm_q   <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      acc_q  <= acc_d;
      vld_q  <= vld_d;
      ferr_q <= ferr_d;
      mm_q   <= mm_d;
    end
  end

  assign cfg          = cfg_q;
  assign cfg_vld      = vld_q;
  assign fchk_err     = ferr_q;
  assign cfg_mismatch = mm_q;

endmodule

// File: rtl/ila_checker.sv
// RX ILA checker: tracks octet/frame/multiframe position from the first /R/, checks framing, ends on last /A/.
// Flags/end pulse 1 cycle after the octet; no backpressure, i_vld low simply stalls all counters.
module ila_checker
  import jesd204b_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_vld,
  input  logic       i_k,
  input  logic       i_start,
  input  logic [7:0] i_F,
  input  logic [4:0] i_K,
  input  logic [7:0] i_ila_multiframe_length,
  output logic [7:0] o_DID,
  output logic [3:0] o_BID,
  output logic [4:0] o_LID,
  output logic [3:0] o_adjcnt,
  output logic       o_adjdir,
  output logic       o_phadj,
  output logic       o_SCR,
  output logic [4:0] o_L,
  output logic [7:0] o_F,
  output logic [4:0] o_K,
  output logic [7:0] o_M,
  output logic [1:0] o_CS,
  output logic [4:0] o_N,
  output logic [4:0] o_N_ap,
  output logic [4:0] o_S,
  output logic [2:0] o_subclassv,
  output logic [2:0] o_jesdv,
  output logic       o_HD,
  output logic [4:0] o_CF,
  output logic       o_cfg_vld,
  output logic       o_fchk_err,
  output logic       o_cfg_mismatch,
  output logic       o_seq_err,
  output logic       o_seq_end
);

  ila_state_t  state_q, state_d;
  logic [7:0]  oct_q, oct_d;
  logic [4:0]  frm_q, frm_d;
  logic [7:0]  mf_q, mf_d;
  logic [12:0] pos_q, pos_d;  // octet index within the multiframe
  logic        seq_end_q, seq_end_d;
  logic        adv, ok, cap_vld, last_pos;
  ila_cfg_t    cfg;

  always_comb begin
    state_d   = state_q;
    oct_d     = oct_q;
    frm_d     = frm_q;
    mf_d      = mf_q;
    pos_d     = pos_q;
    seq_end_d = 1'b0;
    adv       = 1'b0;
    ok        = 1'b1;
    cap_vld   = 1'b0;
    last_pos  = (oct_q == i_F) && (frm_q == i_K);

    unique case (state_q)
      ST_IDLE:   if (i_start) state_d = ST_WAIT_R;
      ST_WAIT_R: if (i_vld && i_k && i_data == K28_0) begin
        state_d = ST_RUN;
        adv     = 1'b1;
      end
      ST_RUN: if (i_vld) begin
        if (pos_q == '0) begin
          ok = i_k && (i_data == K28_0);
        end else if (last_pos) begin
          ok = i_k && (i_data == K28_3);
        end else if (mf_q == 8'd1 && pos_q == 13'd1) begin
          ok = i_k && (i_data == K28_4);
        end else begin
          ok      = !i_k;
          cap_vld = ok && (mf_q == 8'd1) && (pos_q >= 13'd2) &&
                    (pos_q <= 13'(LINK_CONF_OCTET_NUM + 1));
        end
        if (!ok) begin
          state_d = ST_ERR;
        end else if (last_pos && mf_q == i_ila_multiframe_length) begin
          state_d   = ST_IDLE;
          seq_end_d = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
      ST_ERR: ;
    endcase

    if (adv) begin
      pos_d = pos_q + 13'd1;
      if (oct_q == i_F) begin
        oct_d = '0;
        if (frm_q == i_K) begin
          frm_d = '0;
          pos_d = '0;
          mf_d  = (mf_q == i_ila_multiframe_length) ? 8'd0 : mf_q + 8'd1;
        end else begin
          frm_d = frm_q + 5'd1;
        end
      end else begin
        oct_d = oct_q + 8'd1;
      end
    end

    // Dropping i_start aborts from any state and overrides a completing final /A/.
    if (!i_start) begin
      state_d   = ST_IDLE;
      seq_end_d = 1'b0;
      cap_vld   = 1'b0;
    end
    if (!i_start || state_q == ST_IDLE) begin
      oct_d = '0;
      frm_d = '0;
      mf_d  = '0;
      pos_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      oct_q     <= '0;
      frm_q     <= '0;
      mf_q      <= '0;
      pos_q     <= '0;
      seq_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      oct_q     <= oct_d;
      frm_q     <= frm_d;
      mf_q      <= mf_d;
      pos_q     <= pos_d;
      seq_end_q <= seq_end_d;
    end
  end

  ila_cfg_parser u_cfg_parser (
    .clk          (clk),
    .rst          (rst),
    .clr          (state_q == ST_IDLE),
    .cap_vld      (cap_vld),
    .cap_idx      (4'(pos_q - 13'd2)),
    .cap_dat      (i_data),
    .exp_f        (i_F),
    .exp_k        (i_K),
    .cfg          (cfg),
    .cfg_vld      (o_cfg_vld),
    .fchk_err     (o_fchk_err),
    .cfg_mismatch (o_cfg_mismatch)
  );

  assign o_DID       = cfg.did;
  assign o_BID       = cfg.bid;
  assign o_LID       = cfg.lid;
  assign o_adjcnt    = cfg.adjcnt;
  assign o_adjdir    = cfg.adjdir;
  assign o_phadj     = cfg.phadj;
  assign o_SCR       = cfg.scr;
  assign o_L         = cfg.l;
  assign o_F         = cfg.f;
  assign o_K         = cfg.k;
  assign o_M         = cfg.m;
  assign o_CS        = cfg.cs;
  assign o_N         = cfg.n;
  assign o_N_ap      = cfg.n_ap;
  assign o_S         = cfg.s;
  assign o_subclassv = cfg.subclassv;
  assign o_jesdv     = cfg.jesdv;
  assign o_HD        = cfg.hd;
  assign o_CF        = cfg.cf;
  assign o_seq_err   = (state_q == ST_ERR);
  assign o_seq_end   = seq_end_q;

endmodule
